// File: rtl/beta_pkg.sv
// beta_pkg: shared types and constants for the beta data-memory arbiter
package beta_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_IF,
        GNT_RD,
        GNT_WR
    } arb_grant_t;

    localparam int ARB_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/beta_arb_prio.sv
// beta_arb_prio: combinational grant select; round-robin IF/LSU tie-break when BETA_DMEM_ARB_RR_EN is defined
module beta_arb_prio
    import beta_pkg::*;
(
    input  logic       if_req_i,
    input  logic       rd_req_i,
    input  logic       wr_req_i,
    input  logic       ptr_i,
    output arb_grant_t gnt_o
);

    arb_grant_t lsu_gnt;

    // Writes always go ahead of reads so LSU ordering is kept
    always_comb begin
        lsu_gnt = wr_req_i ? GNT_WR : (rd_req_i ? GNT_RD : GNT_NONE);
    end

`ifdef BETA_DMEM_ARB_RR_EN
    // ptr_i=1 hands an IF/LSU tie to the LSU, ptr_i=0 hands it to fetch
    always_comb begin
        gnt_o = (lsu_gnt != GNT_NONE && (ptr_i || !if_req_i)) ? lsu_gnt
              : (if_req_i ? GNT_IF : GNT_NONE);
    end
`else
    logic unused_ptr;
    assign unused_ptr = ptr_i;

    // Fixed priority: any LSU request beats fetch
    always_comb begin
        gnt_o = (lsu_gnt != GNT_NONE) ? lsu_gnt : (if_req_i ? GNT_IF : GNT_NONE);
    end
`endif

endmodule

// File: rtl/beta_dmem_arbiter.sv
// beta_dmem_arbiter: shares one memory port between fetch, LSU read and LSU write (round-robin under BETA_DMEM_ARB_RR_EN)
module beta_dmem_arbiter
    import beta_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int TimeoutCycles = ARB_TIMEOUT_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      if_req_i,
    input  logic [AddressWidth-1:0]   if_addr_i,
    output logic                      if_ready_o,
    output logic                      if_valid_o,
    output logic [DataWidth-1:0]      if_rdata_o,
    input  logic                      rd_req_i,
    input  logic [AddressWidth-1:0]   rd_addr_i,
    input  logic [DataWidth/8-1:0]    rd_strb_i,
    output logic                      rd_ready_o,
    output logic                      rd_valid_o,
    output logic [DataWidth-1:0]      rd_rdata_o,
    input  logic                      wr_req_i,
    input  logic [AddressWidth-1:0]   wr_addr_i,
    input  logic [DataWidth-1:0]      wr_data_i,
    input  logic [DataWidth/8-1:0]    wr_strb_i,
    output logic                      wr_ready_o,
    output logic                      wr_valid_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [AddressWidth-1:0]   mem_addr_o,
    output logic [DataWidth-1:0]      mem_wdata_o,
    output logic [DataWidth/8-1:0]    mem_strb_o,
    input  logic                      mem_ready_i,
    input  logic                      mem_valid_i,
    input  logic [DataWidth-1:0]      mem_rdata_i,
    output logic                      arb_err_o
);

    localparam int SW = DataWidth / 8;
    localparam int CW = $clog2(TimeoutCycles + 1);

    arb_state_t              state_q, state_d;
    arb_grant_t              gnt_q, gnt_d, sel;
    arb_grant_t              rsp_q, rsp_d;
    logic                    we_q, we_d;
    logic [AddressWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0]    wdata_q, wdata_d;
    logic [SW-1:0]           strb_q, strb_d;
    logic [DataWidth-1:0]    rdata_q, rdata_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    ptr;
    logic                    accept;
    logic                    direct;

    beta_arb_prio u_prio (
        .if_req_i (if_req_i),
        .rd_req_i (rd_req_i),
        .wr_req_i (wr_req_i),
        .ptr_i    (ptr),
        .gnt_o    (sel)
    );

`ifdef BETA_DMEM_ARB_RR_EN
    logic ptr_q, ptr_d;

    // After a grant the other class (IF vs LSU) wins the next tie
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ARB_IDLE && sel != GNT_NONE) ptr_d = (sel == GNT_IF);
    end

    // Pointer register, reset to favour fetch
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) ptr_q <= 1'b0;
        else         ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
`else
    assign ptr = 1'b0;
`endif

    // Next-state, payload capture, response and timeout logic
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        rsp_d   = GNT_NONE;
        rdata_d = '0;
        err_d   = 1'b0;
        cnt_d   = '0;
        case (state_q)
            ARB_IDLE: begin
                if (sel != GNT_NONE) begin
                    state_d = ARB_ISSUE;
                    gnt_d   = sel;
                    we_d    = (sel == GNT_WR);
                    addr_d  = (sel == GNT_WR) ? wr_addr_i : (sel == GNT_RD) ? rd_addr_i : if_addr_i;
                    wdata_d = (sel == GNT_WR) ? wr_data_i : '0;
                    strb_d  = (sel == GNT_WR) ? wr_strb_i : (sel == GNT_RD) ? rd_strb_i : '1;
                end
            end
            ARB_ISSUE: begin
                if (mem_ready_i) state_d = mem_valid_i ? ARB_IDLE : ARB_WAIT;
            end
            ARB_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (mem_valid_i) begin
                    state_d = ARB_IDLE;
                    rsp_d   = gnt_q;
                    rdata_d = mem_rdata_i;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(TimeoutCycles - 1)) begin
                    state_d = ARB_IDLE;
                    rsp_d   = gnt_q;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State, payload and registered-response flops
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ARB_IDLE;
            gnt_q   <= GNT_NONE;
            rsp_q   <= GNT_NONE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rsp_q   <= rsp_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign accept = (state_q == ARB_ISSUE) && mem_ready_i;
    assign direct = accept && mem_valid_i;

    assign mem_req_o   = (state_q == ARB_ISSUE);
    assign mem_we_o    = mem_req_o && we_q;
    assign mem_addr_o  = mem_req_o ? addr_q : '0;
    assign mem_wdata_o = mem_req_o ? wdata_q : '0;
    assign mem_strb_o  = mem_req_o ? strb_q : '0;

    assign if_ready_o = accept && (gnt_q == GNT_IF);
    assign rd_ready_o = accept && (gnt_q == GNT_RD);
    assign wr_ready_o = accept && (gnt_q == GNT_WR);

    // A same-cycle ready+valid completes immediately, so that response bypasses the register
    assign if_valid_o = (rsp_q == GNT_IF) || (direct && gnt_q == GNT_IF);
    assign rd_valid_o = (rsp_q == GNT_RD) || (direct && gnt_q == GNT_RD);
    assign wr_valid_o = (rsp_q == GNT_WR) || (direct && gnt_q == GNT_WR);

    assign if_rdata_o = (rsp_q == GNT_IF) ? rdata_q : (direct && gnt_q == GNT_IF) ? mem_rdata_i : '0;
    assign rd_rdata_o = (rsp_q == GNT_RD) ? rdata_q : (direct && gnt_q == GNT_RD) ? mem_rdata_i : '0;

    assign arb_err_o = err_q;

endmodule

// File: tb/tb_beta_dmem_arbiter.sv
// tb_beta_dmem_arbiter: directed self-checking bench for beta_dmem_arbiter
module tb_beta_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_req, rd_req, wr_req;
    logic [31:0] if_addr, rd_addr, wr_addr, wr_data;
    logic [3:0]  rd_strb, wr_strb;
    logic        if_ready, if_valid, rd_ready, rd_valid, wr_ready, wr_valid;
    logic [31:0] if_rdata, rd_rdata;
    logic        mem_req, mem_we, mem_ready, mem_valid, arb_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_strb;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    beta_dmem_arbiter #(
        .DataWidth     (32),
        .AddressWidth  (32),
        .TimeoutCycles (8)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_ready_o  (if_ready),
        .if_valid_o  (if_valid),
        .if_rdata_o  (if_rdata),
        .rd_req_i    (rd_req),
        .rd_addr_i   (rd_addr),
        .rd_strb_i   (rd_strb),
        .rd_ready_o  (rd_ready),
        .rd_valid_o  (rd_valid),
        .rd_rdata_o  (rd_rdata),
        .wr_req_i    (wr_req),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .wr_strb_i   (wr_strb),
        .wr_ready_o  (wr_ready),
        .wr_valid_o  (wr_valid),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_strb_o  (mem_strb),
        .mem_ready_i (mem_ready),
        .mem_valid_i (mem_valid),
        .mem_rdata_i (mem_rdata),
        .arb_err_o   (arb_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_addr;
        logic [31:0] exp_rr [4];
        rstn = 1'b0;
        {if_req, rd_req, wr_req, mem_ready, mem_valid} = '0;
        {if_addr, rd_addr, wr_addr, wr_data, mem_rdata} = '0;
        {rd_strb, wr_strb} = '0;
        #2;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_strb", mem_strb, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_err", arb_err, 0);
        cyc(); cyc();
        rstn = 1'b1;

        // Fetch read: request cycle 0, ready 2, valid 4, data out at 5
        cyc();
        if_req = 1'b1; if_addr = 32'h100; #1;
        chk("if_c0_mem_req", mem_req, 0);
        cyc(); #1;
        chk("if_c1_mem_req", mem_req, 1);
        chk("if_c1_addr", mem_addr, 32'h100);
        chk("if_c1_strb", mem_strb, 4'hF);
        chk("if_c1_we", mem_we, 0);
        chk("if_c1_ready", if_ready, 0);
        cyc();
        mem_ready = 1'b1; #1;
        chk("if_c2_ready", if_ready, 1);
        chk("if_c2_mem_req", mem_req, 1);
        cyc();
        if_req = 1'b0; mem_ready = 1'b0; #1;
        chk("if_c3_mem_req", mem_req, 0);
        chk("if_c3_ready", if_ready, 0);
        cyc();
        mem_valid = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
        chk("if_c4_valid", if_valid, 0);
        cyc();
        mem_valid = 1'b0; mem_rdata = 32'h0; #1;
        chk("if_c5_valid", if_valid, 1);
        chk("if_c5_rdata", if_rdata, 32'hDEADBEEF);
        chk("if_c5_rd_valid", rd_valid, 0);
        cyc(); #1;
        chk("if_c6_valid", if_valid, 0);
        chk("if_c6_rdata", if_rdata, 0);

        // Write and read together: write goes first
        wr_req = 1'b1; wr_addr = 32'h20; wr_data = 32'h12345678; wr_strb = 4'hF;
        rd_req = 1'b1; rd_addr = 32'h44; rd_strb = 4'h3;
        cyc(); #1;
        chk("wr_we", mem_we, 1);
        chk("wr_addr", mem_addr, 32'h20);
        chk("wr_wdata", mem_wdata, 32'h12345678);
        chk("wr_strb", mem_strb, 4'hF);
        mem_ready = 1'b1; #1;
        chk("wr_ready", wr_ready, 1);
        chk("wr_rd_ready", rd_ready, 0);
        cyc();
        wr_req = 1'b0; mem_ready = 1'b0; mem_valid = 1'b1; #1;
        chk("wr_wait_valid", wr_valid, 0);
        chk("wr_wait_mem_req", mem_req, 0);
        cyc();
        mem_valid = 1'b0; #1;
        chk("wr_valid", wr_valid, 1);
        chk("wr_idle_mem_req", mem_req, 0);
        cyc(); #1;
        chk("rd_we", mem_we, 0);
        chk("rd_addr", mem_addr, 32'h44);
        chk("rd_strb", mem_strb, 4'h3);
        chk("rd_wdata", mem_wdata, 0);

        // Same-cycle ready and valid completes directly
        mem_ready = 1'b1; mem_valid = 1'b1; mem_rdata = 32'hCAFE0001; #1;
        chk("dir_rd_ready", rd_ready, 1);
        chk("dir_rd_valid", rd_valid, 1);
        chk("dir_rd_rdata", rd_rdata, 32'hCAFE0001);
        cyc();
        rd_req = 1'b0; mem_ready = 1'b0; mem_valid = 1'b0; mem_rdata = 32'h0;
        if_req = 1'b1; if_addr = 32'h104; #1;
        chk("dir_k1_mem_req", mem_req, 0);
        chk("dir_k1_rd_valid", rd_valid, 0);
        cyc(); #1;
        chk("dir_k2_mem_req", mem_req, 1);
        chk("dir_k2_addr", mem_addr, 32'h104);
        mem_ready = 1'b1; mem_valid = 1'b1; mem_rdata = 32'h55; #1;
        chk("dir_if_valid", if_valid, 1);
        chk("dir_if_rdata", if_rdata, 32'h55);
        cyc();
        mem_ready = 1'b0; mem_valid = 1'b0; mem_rdata = 32'h0;

        // IF and RD held continuously; last grant was IF
`ifdef BETA_DMEM_ARB_RR_EN
        exp_rr = '{32'h80, 32'h100, 32'h80, 32'h100};
`else
        exp_rr = '{32'h80, 32'h80, 32'h80, 32'h80};
`endif
        if_req = 1'b1; if_addr = 32'h100; rd_req = 1'b1; rd_addr = 32'h80; rd_strb = 4'hF;
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            chk($sformatf("arb_grant%0d", i), mem_addr, exp_rr[i]);
            mem_ready = 1'b1; mem_valid = 1'b1;
            cyc();
            mem_ready = 1'b0; mem_valid = 1'b0;
        end
        if_req = 1'b0; rd_req = 1'b0;

        // Timeout on a read that never gets a response
        cyc();
        rd_req = 1'b1; rd_addr = 32'h90;
        cyc();
        mem_ready = 1'b1; #1;
        chk("to_rd_ready", rd_ready, 1);
        cyc();
        rd_req = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < 7; i++) cyc();
        #1;
        chk("to_w7_err", arb_err, 0);
        chk("to_w7_valid", rd_valid, 0);
        cyc();
        mem_valid = 1'b1; mem_rdata = 32'h77; #1;
        chk("to_err", arb_err, 1);
        chk("to_rd_valid", rd_valid, 1);
        chk("to_rd_rdata", rd_rdata, 0);
        cyc(); #1;
        chk("to_after_err", arb_err, 0);
        chk("to_late_valid", rd_valid, 0);
        chk("to_late_mem_req", mem_req, 0);
        mem_valid = 1'b0; mem_rdata = 32'h0;

        // Reset dropped during WAIT
        if_req = 1'b1; if_addr = 32'h300;
        cyc();
        mem_ready = 1'b1;
        cyc();
        if_req = 1'b0; mem_ready = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h99;
        #1;
        rstn = 1'b0; #1;
        chk("rw_mem_req", mem_req, 0);
        chk("rw_if_valid", if_valid, 0);
        chk("rw_strb", mem_strb, 0);
        cyc();
        mem_valid = 1'b0; mem_rdata = 32'h0; #1;
        chk("rw_hold_if_valid", if_valid, 0);
        rstn = 1'b1;
        cyc();
        if_req = 1'b1; if_addr = 32'h200; rd_req = 1'b1; rd_addr = 32'h84;
`ifdef BETA_DMEM_ARB_RR_EN
        exp_addr = 32'h200;
`else
        exp_addr = 32'h84;
`endif
        cyc(); #1;
        chk("post_rst_mem_req", mem_req, 1);
        chk("post_rst_addr", mem_addr, exp_addr);
        mem_ready = 1'b1; mem_valid = 1'b1; mem_rdata = 32'hA5A5; #1;
        chk("post_rst_valid", if_valid | rd_valid, 1);
        cyc();
        if_req = 1'b0; rd_req = 1'b0; mem_ready = 1'b0; mem_valid = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/beta_dmem_arbiter.md
Name: beta_dmem_arbiter

Overview:
- Shares one unified memory port between three requesters: instruction fetch read (IF), LSU read (RD), LSU write (WR).
- Sits between the fetch stage / exe-stage LSU ports and the single memory bus.
- Grants one requester at a time and keeps one transaction outstanding.
- Routes the response back to the granted requester.
- Flags a timeout error if memory never responds.

Parameters:
- DataWidth, 32, data bus width.
- AddressWidth, 32, address bus width.
- TimeoutCycles, 64, max cycles waiting for response before error (>=2).

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- if_req_i  in  1  fetch read request.
- if_addr_i  in  AddressWidth  fetch address.
- if_ready_o  out  1  fetch request accepted by memory.
- if_valid_o  out  1  fetch response valid.
- if_rdata_o  out  DataWidth  fetch read data.
- rd_req_i  in  1  LSU read request.
- rd_addr_i  in  AddressWidth  LSU read address.
- rd_strb_i  in  DataWidth/8  LSU read byte strobe.
- rd_ready_o  out  1  LSU read accepted.
- rd_valid_o  out  1  LSU read response valid.
- rd_rdata_o  out  DataWidth  LSU read data.
- wr_req_i  in  1  LSU write request.
- wr_addr_i  in  AddressWidth  LSU write address.
- wr_data_i  in  DataWidth  LSU write data.
- wr_strb_i  in  DataWidth/8  LSU write strobe.
- wr_ready_o  out  1  LSU write accepted.
- wr_valid_o  out  1  LSU write completion.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  AddressWidth  memory address.
- mem_wdata_o  out  DataWidth  memory write data.
- mem_strb_o  out  DataWidth/8  memory strobe (all ones for IF).
- mem_ready_i  in  1  memory accepts request.
- mem_valid_i  in  1  memory response valid.
- mem_rdata_i  in  DataWidth  memory read data.
- arb_err_o  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (async, rstn_i=0):
  - state=IDLE; all outputs 0; mem_strb_o=0.
  - Round-robin pointer points to IF.
  - Timeout counter=0.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_i is high, compute grant and register grant, we, addr, wdata and strb; go to ISSUE.
  - Otherwise stay in IDLE.
  - Minimum latency: request at cycle N -> mem_req_o at N+1.
- Grant priority (fixed):
  - WR > RD: LSU ordering is preserved.
  - The LSU-vs-IF choice is governed by the optional feature.
- ISSUE:
  - mem_req_o=1 with the registered payload, held stable until mem_ready_i.
  - On mem_ready_i: pulse the granted ready_o for one cycle and go to WAIT.
  - If mem_valid_i arrives in the same cycle as mem_ready_i, complete directly: ready_o and valid_o pulse together, return to IDLE.
- WAIT:
  - mem_req_o=0.
  - On mem_valid_i: pulse the granted valid_o for one cycle; rdata_o = mem_rdata_i, registered (valid one cycle after mem_valid_i).
  - Then return to IDLE; update the pointer to the non-granted class.
- Timeout:
  - The counter increments each WAIT cycle and clears on leaving WAIT.
  - At TimeoutCycles-1 with no mem_valid_i: pulse arb_err_o and the granted valid_o with rdata_o=0, return to IDLE.
  - A late mem_valid_i arriving in IDLE is ignored.
- Requester rules:
  - Hold req and payload until ready_o.
  - Deasserting req before ready_o is illegal.
  - A new request may be raised the cycle after valid_o.
- rdata outputs:
  - Non-granted valid_o/rdata_o remain 0.
  - wr_valid_o carries no data.
- Simultaneous requests in IDLE resolve within the same cycle, with no bubble between back-to-back grants beyond the IDLE cycle.

Optional Feature:
- BETA_DMEM_ARB_RR_EN defined:
  - IF and LSU (RD/WR) alternate by round-robin pointer; the class granted last loses on a tie.
- Undefined:
  - Fixed priority WR > RD > IF, with no pointer register.
  - Fetch may starve under continuous LSU traffic.

Decomposition:
- beta_pkg gains:
  - typedef enum arb_state_t {ARB_IDLE, ARB_ISSUE, ARB_WAIT}.
  - typedef enum arb_grant_t {GNT_NONE, GNT_IF, GNT_RD, GNT_WR}.
  - ARB_TIMEOUT_DEFAULT constant.
- One sub-module, beta_arb_prio: combinational grant select from the requests plus the pointer (the pointer is bypassed when the macro is off).

Test Plan:
- if_req_i=1, addr=0x100; memory gives ready at cycle 2 and valid at cycle 4 with rdata=0xDEADBEEF -> mem_req_o high at cycle 1; if_ready_o pulses at 2; if_valid_o at 5 with if_rdata_o=0xDEADBEEF.
- wr_req_i and rd_req_i both high, wr_addr=0x20, data=0x12345678, strb=0xF -> write issued first with mem_we_o=1; read issued after wr_valid_o.
- RR on: IF and RD held high continuously -> grants alternate IF, RD, IF, RD…. RR off: RD served every time until it drops.
- mem_ready_i and mem_valid_i asserted in the same ISSUE cycle -> ready_o and valid_o pulse together; next request issues 2 cycles later.
- Memory never responds after ready -> arb_err_o and rd_valid_o pulse after TimeoutCycles WAIT cycles, rd_rdata_o=0, state back to IDLE.
- rstn_i dropped during WAIT -> all outputs 0 immediately; after release, a fresh if_req_i is granted normally.
